// File: rtl/alu_dispatch.sv
// Issue stage for the 8-bit compare/logic ALU: op FIFO, head drives the ALU, result is registered.
// Latency: op pushed at edge N into an idle block is captured at edge N+1; 1 op/cycle sustained.
// Backpressure: in_ready = !full (no same-cycle pop credit); out_ready low stalls result and pops.
// Optional ALU_ERR_CNT_EN adds a saturating illegal-op counter on err_cnt.

module alu_dispatch_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdat,
    output logic [W-1:0]     rdat,
    output logic [PTR_W:0]   lvl,
    output logic             full,
    output logic             empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
        end
    end

    assign rdat  = mem[rd_ptr];
    assign full  = (lvl == (PTR_W+1)'(DEPTH));
    assign empty = (lvl == '0);
endmodule

module alu_dispatch #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [3:0]       in_ctrl,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [7:0]       alu_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_s,
    output logic             out_err,
    output logic [PTR_W:0]   fifo_lvl
`ifdef ALU_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ctrl;
    } op_t;

    op_t  in_op;
    op_t  head;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic legal;

    assign in_op = '{a: in_a, b: in_b, ctrl: in_ctrl};

    // in_ready depends only on registered level, so no ready->ready combinational path.
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && (!out_valid || out_ready);

    alu_dispatch_fifo #(
        .W     ($bits(op_t)),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdat  (in_op),
        .rdat  (head),
        .lvl   (fifo_lvl),
        .full  (full),
        .empty (empty)
    );

    assign alu_a    = empty ? 8'h00 : head.a;
    assign alu_b    = empty ? 8'h00 : head.b;
    assign alu_ctrl = empty ? 4'd0  : head.ctrl;
    assign legal    = (alu_ctrl >= 4'd2) && (alu_ctrl <= 4'd11);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= 8'h00;
            out_err   <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            if (legal) begin
                out_s   <= alu_s;
                out_err <= 1'b0;
            end else begin
                out_s   <= 8'h00;
                out_err <= 1'b1;
            end
        end else if (out_ready) begin
            // Nothing to refill the result register: drop valid, keep last data visible.
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (pop && !legal && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed + randomized bench for alu_dispatch; a queue-based reference model predicts every output.
module tb_alu_dispatch;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [3:0]       in_ctrl;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [3:0]       alu_ctrl;
    logic [7:0]       alu_s;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_s;
    logic             out_err;
    logic [PTR_W:0]   fifo_lvl;
`ifdef ALU_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    alu_dispatch #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ctrl   (in_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_s     (alu_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_err   (out_err),
        .fifo_lvl  (fifo_lvl)
`ifdef ALU_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU; illegal codes return junk so the DUT must substitute 8'h00.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] c);
        case (c)
            4'd2:    return a + b;
            4'd3:    return a + 8'd1;
            4'd4:    return a - 8'd1;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ~a;
            4'd9:    return {7'd0, a > b};
            4'd10:   return {7'd0, a < b};
            4'd11:   return {7'd0, a == b};
            default: return 8'h5A;
        endcase
    endfunction

    always_comb alu_s = alu_ref(alu_a, alu_b, alu_ctrl);

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ctrl;
    } op_t;

    op_t        q[$];
    logic       m_valid;
    logic [7:0] m_s;
    logic       m_err;
    int         m_cnt;
    int         n_chk;
    int         n_fail;
    int         n_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_ctrl  = c;
    endtask

    // One clock: predict from pre-edge inputs, advance, then compare everything.
    task automatic tick();
        bit  acc;
        bit  pop;
        op_t nop;
        op_t h;
        acc = in_valid && (q.size() < DEPTH);
        pop = (q.size() != 0) && (!m_valid || out_ready);
        nop = '{a: in_a, b: in_b, ctrl: in_ctrl};
        if (in_valid && in_ready) n_acc++;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_s     = 8'h00;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else begin
            if (pop) begin
                h = q.pop_front();
                m_valid = 1'b1;
                if (h.ctrl >= 2 && h.ctrl <= 11) begin
                    m_s   = alu_ref(h.a, h.b, h.ctrl);
                    m_err = 1'b0;
                end else begin
                    m_s   = 8'h00;
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) q.push_back(nop);
        end
        chk("in_ready",  in_ready,  q.size() < DEPTH);
        chk("fifo_lvl",  fifo_lvl,  q.size());
        chk("out_valid", out_valid, m_valid);
        chk("out_s",     out_s,     m_s);
        chk("out_err",   out_err,   m_err);
        chk("alu_a",     alu_a,     q.size() != 0 ? q[0].a : 8'h00);
        chk("alu_b",     alu_b,     q.size() != 0 ? q[0].b : 8'h00);
        chk("alu_ctrl",  alu_ctrl,  q.size() != 0 ? q[0].ctrl : 4'd0);
`ifdef ALU_ERR_CNT_EN
        chk("err_cnt",   err_cnt,   m_cnt);
`endif
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        n_acc     = 0;
        m_valid   = 1'b0;
        m_s       = 8'h00;
        m_err     = 1'b0;
        m_cnt     = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'd0);

        // Reset held two cycles, then idle state.
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_s",     out_s,     8'h00);
        chk("rst_out_err",   out_err,   1'b0);
        chk("rst_fifo_lvl",  fifo_lvl,  0);
        chk("rst_in_ready",  in_ready,  1'b1);
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Single op latency: increment 5 -> 6.
        out_ready = 1'b1;
        drive(1'b1, 8'h05, 8'h00, 4'd3);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        chk("lat_not_yet", out_valid, 1'b0);
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_s",     out_s,     8'h06);
        chk("lat_err",   out_err,   1'b0);
        tick();

        // Capacity: six offered with out_ready low, five taken.
        out_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 8'h00, 4'd3);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        chk("cap_accepted", n_acc,    5);
        chk("cap_lvl",      fifo_lvl, 4);
        chk("cap_in_ready", in_ready, 1'b0);
        chk("cap_head_s",   out_s,    8'h11);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("order_valid", out_valid, 1'b1);
            chk("order_s",     out_s,     8'h11 + 8'(k));
        end
        tick();
        chk("drain_valid", out_valid, 1'b0);
        chk("drain_hold",  out_s,     8'h15);

        // Illegal code.
        drive(1'b1, 8'h01, 8'h01, 4'd13);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        tick();
        chk("ill_s",   out_s,   8'h00);
        chk("ill_err", out_err, 1'b1);
`ifdef ALU_ERR_CNT_EN
        chk("ill_cnt", err_cnt, 8'd1);
`endif

        // Compare/decrement pass-through cases.
        drive(1'b1, 8'h80, 8'h7F, 4'd9);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        tick();
        chk("gt_s",   out_s,   8'h01);
        chk("gt_err", out_err, 1'b0);
        drive(1'b1, 8'h00, 8'h00, 4'd4);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        tick();
        chk("dec_s", out_s, 8'hFF);
        drive(1'b1, 8'hAA, 8'hAA, 4'd11);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        tick();
        chk("eq_s", out_s, 8'h01);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  4'($urandom_range(0, 15)));
            out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Reset mid-operation: three queued plus a pending result.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i), 8'h00, 4'd2);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 4'd0);
        chk("mid_lvl",   fifo_lvl,  3);
        chk("mid_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_lvl",   fifo_lvl,  0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready,  1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
